spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter_pkg.sv | 18 +
 rtl/spi_arbiter_if.sv | 13 +
 rtl/spi_arbiter_rr_pick.sv | 27 ++
 rtl/spi_arbiter.sv | 130 +++++++++++++
 tb/tb_spi_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_arbiter_pkg.sv
// Shared types for the SPI arbiter: FSM state encoding and DAC register codes.
package spi_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_WAIT_DROP = 2'd2,
    ST_RELEASE   = 2'd3
  } state_t;

  localparam logic [3:0] DAC_CODE_WRITE = 4'b0001;
  localparam logic [3:0] DAC_CODE_READ  = 4'b1001;

  function automatic logic [23:0] dac_word(input logic [3:0] code, input logic [19:0] data);
    return {code, data};
  endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Link between the arbiter (master modport) and the shared SPI master engine (slave modport).
interface spi_arbiter_if #(
  parameter int WID = 24
);
  logic           mst_arm;
  logic           mst_ss;
  logic [WID-1:0] mst_to;
  logic [WID-1:0] mst_from;
  logic           mst_finished;

  modport master (output mst_arm, mst_ss, mst_to, input mst_from, mst_finished);
  modport slave  (input mst_arm, mst_ss, mst_to, output mst_from, mst_finished);
endinterface

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, one-hot grant plus valid.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          vld
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among PORTS requesters; 1-cycle request-to-arm latency,
// requesters hold req_arm until req_finished. Optional watchdog under SPI_ARBITER_TIMEOUT_EN.
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int PORTS       = 2,
  parameter int WID         = 24,
  parameter int TIMEOUT_WID = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORTS-1:0]       req_arm,
  input  logic [PORTS*WID-1:0]   req_to,
  output logic [PORTS-1:0]       req_finished,
  output logic [WID-1:0]         req_from,
  output logic [PORTS-1:0]       grant,
  spi_arbiter_if.master          mst,
  input  logic [TIMEOUT_WID-1:0] timeout_cycles,
  output logic                   timeout_flag
);

  localparam int PW = $clog2(PORTS);

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     owner;
  logic [PW-1:0]     next_ptr;
  logic [PORTS-1:0]  pick_gnt;
  logic              pick_vld;
  logic [PW-1:0]     pick_idx;
  logic              wd_fire;

  rr_pick #(.N(PORTS), .PW(PW)) u_pick (
    .req (req_arm),
    .ptr (ptr),
    .gnt (pick_gnt),
    .vld (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (pick_gnt[i]) pick_idx = PW'(i);
    end
  end

  assign next_ptr = (owner == PW'(PORTS - 1)) ? '0 : owner + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      owner        <= '0;
      grant        <= '0;
      req_finished <= '0;
      req_from     <= '0;
      mst.mst_arm  <= 1'b0;
      mst.mst_ss   <= 1'b0;
      mst.mst_to   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            grant       <= pick_gnt;
            owner       <= pick_idx;
            mst.mst_arm <= 1'b1;
            mst.mst_ss  <= 1'b1;
            mst.mst_to  <= req_to[pick_idx*WID +: WID];
            state       <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          // A watchdog expiry abandons the transfer without reporting completion.
          if (wd_fire) begin
            mst.mst_arm <= 1'b0;
            mst.mst_ss  <= 1'b0;
            grant       <= '0;
            ptr         <= next_ptr;
            state       <= ST_IDLE;
          end else if (mst.mst_finished) begin
            req_from     <= mst.mst_from;
            req_finished <= grant;
            state        <= ST_WAIT_DROP;
          end
        end
        ST_WAIT_DROP: begin
          if (!req_arm[owner]) begin
            req_finished <= '0;
            mst.mst_arm  <= 1'b0;
            mst.mst_ss   <= 1'b0;
            state        <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (wd_fire || !mst.mst_finished) begin
            grant <= '0;
            ptr   <= next_ptr;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_ARBITER_TIMEOUT_EN
  logic [TIMEOUT_WID-1:0] wd;
  logic                   counting;

  assign counting = (state == ST_ARMED) || (state == ST_RELEASE);
  assign wd_fire  = counting && (timeout_cycles != '0) &&
                    (wd == timeout_cycles - TIMEOUT_WID'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd           <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (wd_fire) timeout_flag <= 1'b1;
      wd <= (counting && !wd_fire) ? wd + TIMEOUT_WID'(1) : '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles;
  assign wd_fire        = 1'b0;
  assign timeout_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a transaction-level reference model checked every cycle.
module tb_spi_arbiter;
  import spi_arbiter_pkg::*;

  localparam int PORTS = 2;
  localparam int WID   = 24;
  localparam int TW    = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [PORTS-1:0]     req_arm;
  logic [PORTS*WID-1:0] req_to;
  logic [PORTS-1:0]     req_finished;
  logic [WID-1:0]       req_from;
  logic [PORTS-1:0]     grant;
  logic [TW-1:0]        timeout_cycles;
  logic                 timeout_flag;

  spi_arbiter_if #(.WID(WID)) mif ();

  spi_arbiter #(.PORTS(PORTS), .WID(WID), .TIMEOUT_WID(TW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_arm        (req_arm),
    .req_to         (req_to),
    .req_finished   (req_finished),
    .req_from       (req_from),
    .grant          (grant),
    .mst            (mif),
    .timeout_cycles (timeout_cycles),
    .timeout_flag   (timeout_flag)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural SPI master: raises finished lat cycles after arm, holds it until arm drops.
  int             lat  = 10;
  bit             hang = 1'b0;
  logic [WID-1:0] resp_word = '0;

  initial begin
    int cnt;
    cnt = 0;
    mif.mst_finished = 1'b0;
    mif.mst_from     = '0;
    forever begin
      @(posedge clk); #2;
      if (rst || !mif.mst_arm) begin
        mif.mst_finished = 1'b0;
        cnt = 0;
      end else if (cnt >= lat && !hang) begin
        mif.mst_finished = 1'b1;
        mif.mst_from     = resp_word;
      end else begin
        cnt++;
      end
    end
  end

  // Reference model: one transaction at a time, phase 0 free, 1 in flight, 2 reported, 3 draining.
  int               ph = 0, m_own = 0, m_ptr = 0, wdc = 0;
  bit               m_fire;
  logic [PORTS-1:0] m_grant = '0, m_fin = '0;
  logic             m_arm = 1'b0, m_tflag = 1'b0;
  logic [WID-1:0]   m_to = '0, m_from = '0;
  logic             p_rst = 1'b1, p_fin = 1'b0;
  logic [PORTS-1:0] p_arm = '0;
  logic [PORTS*WID-1:0] p_to = '0;
  logic [WID-1:0]   p_from = '0;
  int               glog[$];

  function automatic int rr(input logic [PORTS-1:0] r, input int p);
    for (int k = 0; k < PORTS; k++) if (r[(p + k) % PORTS]) return (p + k) % PORTS;
    return -1;
  endfunction

  task automatic m_release();
    m_grant = '0;
    m_arm   = 1'b0;
    m_fin   = '0;
    m_ptr   = (m_own + 1) % PORTS;
    ph      = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      m_fire = 1'b0;
      if (rst || p_rst) begin
        ph = 0; m_ptr = 0; wdc = 0; m_grant = '0; m_fin = '0;
        m_arm = 1'b0; m_to = '0; m_from = '0; m_tflag = 1'b0;
      end else begin
`ifdef SPI_ARBITER_TIMEOUT_EN
        if (ph == 1 || ph == 3) begin
          wdc++;
          if (timeout_cycles != 0 && wdc == int'(timeout_cycles)) m_fire = 1'b1;
        end
`endif
        case (ph)
          0: if (p_arm != 0) begin
            m_own = rr(p_arm, m_ptr);
            m_grant = '0;
            m_grant[m_own] = 1'b1;
            m_arm = 1'b1;
            m_to  = p_to[m_own*WID +: WID];
            ph = 1; wdc = 0;
            glog.push_back(m_own);
          end
          1: if (m_fire) begin
            m_tflag = 1'b1; m_release();
          end else if (p_fin) begin
            m_from = p_from; m_fin = m_grant; ph = 2;
          end
          2: if (!p_arm[m_own]) begin
            m_fin = '0; m_arm = 1'b0; ph = 3; wdc = 0;
          end
          3: if (m_fire) begin
            m_tflag = 1'b1; m_release();
          end else if (!p_fin) m_release();
          default: ph = 0;
        endcase
      end
      chk("grant", grant, m_grant);
      chk("grant_onehot", $countones(grant) <= 1, 1);
      chk("req_finished", req_finished, m_fin);
      chk("req_from", req_from, m_from);
      chk("mst_arm", mif.mst_arm, m_arm);
      chk("mst_ss", mif.mst_ss, m_arm);
      chk("mst_to", mif.mst_to, m_to);
      chk("timeout_flag", timeout_flag, m_tflag);
      p_rst  = rst;
      p_arm  = req_arm;
      p_to   = req_to;
      p_fin  = mif.mst_finished;
      p_from = mif.mst_from;
    end
  end

  task automatic wait_fin(input int p, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (req_finished[p]) begin
        ok = 1'b1;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL wait_fin_port%0d: got no req_finished expected one within %0d cycles", p, budget);
  endtask

  task automatic requester(input int p, input int n, input logic [WID-1:0] base);
    bit ok;
    for (int k = 0; k < n; k++) begin
      req_to[p*WID +: WID] = base + WID'(k);
      req_arm[p] = 1'b1;
      wait_fin(p, 400, ok);
      req_arm[p] = 1'b0;
      @(posedge clk); #2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit ok, saw;
    int n;
    rst = 1'b1; req_arm = '0; req_to = '0; timeout_cycles = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_req_finished", req_finished, 0);
    chk("rst_req_from", req_from, 0);
    chk("rst_mst_arm", mif.mst_arm, 0);
    chk("rst_mst_ss", mif.mst_ss, 0);
    chk("rst_mst_to", mif.mst_to, 0);
    chk("rst_timeout_flag", timeout_flag, 0);
    #1 rst = 1'b0;

    // Single transfer on port 0
    @(posedge clk); #2;
    lat = 10; resp_word = 24'h123456;
    req_to[0 +: WID] = dac_word(DAC_CODE_WRITE, 20'hABCDE);
    req_arm[0] = 1'b1;
    #1 chk("arm_before_edge", mif.mst_arm, 0);
    @(posedge clk); #1;
    chk("arm_latency", mif.mst_arm, 1);
    chk("single_mst_to", mif.mst_to, 24'h1ABCDE);
    chk("single_grant", grant, 2'b01);
    wait_fin(0, 100, ok);
    chk("single_req_finished", req_finished, 2'b01);
    chk("single_req_from", req_from, 24'h123456);
    req_arm[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2;

    // Reset returns pointer to 0, then simultaneous arm
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    glog.delete();
    lat = 3; resp_word = 24'h0F0F0F;
    fork
      requester(0, 1, 24'h100000);
      requester(1, 1, 24'h200000);
    join
    chk("simul_count", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("simul_first", glog[0], 0);
      chk("simul_second", glog[1], 1);
    end

    // Continuous re-arm on both ports
    glog.delete();
    fork
      requester(0, 3, 24'h110000);
      requester(1, 3, 24'h220000);
    join
    chk("rr_count", glog.size(), 6);
    for (int k = 0; k < glog.size(); k++) chk($sformatf("rr_order_%0d", k), glog[k], k % 2);

    // req_to change while armed is ignored
    repeat (3) @(posedge clk);
    #2;
    lat = 12; resp_word = 24'hA5A5A5;
    req_to[1*WID +: WID] = dac_word(DAC_CODE_READ, 20'h12345);
    req_arm[1] = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    req_to[1*WID +: WID] = 24'hFFFFFF;
    @(posedge clk); #1;
    chk("hold_mst_to", mif.mst_to, 24'h912345);
    wait_fin(1, 100, ok);
    chk("hold_req_from", req_from, 24'hA5A5A5);
    req_arm[1] = 1'b0;
    repeat (4) @(posedge clk);
    #2;

    // Reset mid-transfer
    lat = 20;
    req_arm[0] = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_ss", mif.mst_ss, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_ss", mif.mst_ss, 0);
    chk("async_rst_arm", mif.mst_arm, 0);
    chk("async_rst_grant", grant, 0);
    req_arm[0] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    saw = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (req_finished != 0) saw = 1'b1;
    end
    chk("no_fin_after_rst", saw, 0);

`ifdef SPI_ARBITER_TIMEOUT_EN
    // Watchdog expiry with a silent master
    #1;
    timeout_cycles = 16'd50; hang = 1'b1;
    req_arm[0] = 1'b1;
    @(posedge clk); #1;
    chk("to_arm", mif.mst_arm, 1);
    n = 0;
    while (!timeout_flag && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    req_arm[0] = 1'b0;
    chk("to_cycles", n, 50);
    chk("to_flag", timeout_flag, 1);
    chk("to_grant", grant, 0);
    chk("to_mst_arm", mif.mst_arm, 0);
    chk("to_no_fin", req_finished, 0);
    hang = 1'b0; lat = 4; resp_word = 24'h00BEEF;
    @(posedge clk); #2;
    requester(1, 1, 24'h300000);
    chk("to_next_req_from", req_from, 24'h00BEEF);
    chk("to_flag_sticky", timeout_flag, 1);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
